// File: rtl/frame_buffer_pkg.sv
// Shared types and per-mode packing constants for the frame-buffer writer.
package frame_buffer_pkg;

  typedef enum logic [1:0] {
    BPP8  = 2'd0,
    BPP4  = 2'd1,
    BPP10 = 2'd2
  } bpp_mode_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    FLUSH   = 2'd2,
    DONE    = 2'd3
  } fbw_state_t;

  localparam int PPW_BPP8     = 4;
  localparam int PPW_BPP4     = 8;
  localparam int PPW_BPP10    = 2;
  localparam int LANE_W_BPP8  = 8;
  localparam int LANE_W_BPP4  = 4;
  localparam int LANE_W_BPP10 = 16;

  // The reserved encoding 3 behaves like 8bpp.
  function automatic bpp_mode_t decode_mode(input logic [1:0] raw);
    case (raw)
      2'd1:    return BPP4;
      2'd2:    return BPP10;
      default: return BPP8;
    endcase
  endfunction

  // Index of the lane that completes a word in the given mode.
  function automatic logic [2:0] last_index(input bpp_mode_t m);
    case (m)
      BPP4:    return 3'(PPW_BPP4 - 1);
      BPP10:   return 3'(PPW_BPP10 - 1);
      default: return 3'(PPW_BPP8 - 1);
    endcase
  endfunction

  // Pixel masked to its mode width and shifted into lane idx.
  function automatic logic [31:0] lane_word(input bpp_mode_t m,
                                            input logic [9:0] pix,
                                            input logic [2:0] idx);
    logic [31:0] ext;
    int          shift;
    case (m)
      BPP4: begin
        ext   = {28'd0, pix[3:0]};
        shift = int'(idx) * LANE_W_BPP4;
      end
      BPP10: begin
        ext   = {22'd0, pix};
        shift = int'(idx) * LANE_W_BPP10;
      end
      default: begin
        ext   = {24'd0, pix[7:0]};
        shift = int'(idx) * LANE_W_BPP8;
      end
    endcase
    return ext << shift;
  endfunction

endpackage

// File: rtl/fbw_word_fifo.sv
// Small show-ahead synchronous FIFO of 32-bit words between the pixel packer
// and the RAM port. A push while full is accepted only if a pop frees a slot
// in the same cycle.
module fbw_word_fifo #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        push,
  input  logic        pop,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        full,
  output logic        empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [31:0]   mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (count == (PW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push & (~full | pop);
  assign pop_ok  = pop & ~empty;
  assign rdata   = mem[rd_ptr];

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage array; contents are don't-care while the slot is empty.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/frame_buffer_writer.sv
// Packs the demosaiced pixel stream into 32-bit words and writes them
// sequentially into the frame-buffer RAM through a small FIFO.
// Optional feature: define FRAME_CHECKSUM_EN to add a 16-bit frame checksum.
module frame_buffer_writer
  import frame_buffer_pkg::*;
#(
  parameter int ADDR_W     = 14,
  parameter int MAX_WORDS  = 16384,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              capture_en,
  input  logic [1:0]        bpp_mode,
  input  logic [9:0]        pixel_data,
  input  logic              pixel_valid,
  input  logic              fv_in,
  input  logic              ram_ready,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  output logic              busy,
  output logic              frame_done,
  output logic [ADDR_W:0]   word_count,
  output logic              overflow
`ifdef FRAME_CHECKSUM_EN
  ,
  output logic [15:0]       checksum
`endif
);

  localparam logic [ADDR_W:0]   MAX_CNT   = (ADDR_W+1)'(MAX_WORDS);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(MAX_WORDS - 1);

  fbw_state_t        state;
  fbw_state_t        state_next;
  bpp_mode_t         mode;
  logic              fv_d;
  logic              fv_rise;
  logic              fv_fall;
  logic [31:0]       pack;
  logic [31:0]       pack_next;
  logic [31:0]       merged;
  logic [2:0]        index;
  logic [2:0]        index_next;
  logic              start_frame;
  logic              push_req;
  logic [31:0]       push_word;
  logic              load_count;
  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_push;
  logic              fifo_pop;
  logic [31:0]       fifo_rdata;
  logic [ADDR_W:0]   wcount;
  logic              cap_reached;
  logic              write_fire;
  logic              drop_push;
  logic              discard;

  assign fv_rise     = fv_in & ~fv_d;
  assign fv_fall     = ~fv_in & fv_d;
  assign cap_reached = (wcount == MAX_CNT);
  assign ram_we      = ~fifo_empty & ~cap_reached;
  assign ram_wdata   = fifo_empty ? 32'd0 : fifo_rdata;
  assign write_fire  = ram_we & ram_ready;
  assign fifo_pop    = ~fifo_empty & (ram_ready | cap_reached);
  assign discard     = ~fifo_empty & cap_reached;
  assign fifo_push   = push_req & (~fifo_full | fifo_pop);
  assign drop_push   = push_req & fifo_full & ~fifo_pop;
  assign busy        = (state != IDLE);
  assign frame_done  = (state == DONE);

  fbw_word_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (fifo_push),
    .pop     (fifo_pop),
    .wdata   (push_word),
    .rdata   (fifo_rdata),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // Next-state logic plus packer control: lane merge, word push and flush.
  always_comb begin
    state_next  = state;
    start_frame = 1'b0;
    push_req    = 1'b0;
    push_word   = 32'd0;
    load_count  = 1'b0;
    pack_next   = pack;
    index_next  = index;
    merged      = pack | lane_word(mode, pixel_data, index);
    case (state)
      IDLE: begin
        if (fv_rise && capture_en) begin
          state_next  = CAPTURE;
          start_frame = 1'b1;
          pack_next   = 32'd0;
          index_next  = 3'd0;
        end
      end
      CAPTURE: begin
        if (fv_fall) begin
          state_next = FLUSH;
          if (index != 3'd0) begin
            push_req  = 1'b1;
            push_word = pack;
          end
          pack_next  = 32'd0;
          index_next = 3'd0;
        end else if (pixel_valid && fv_in) begin
          if (index == last_index(mode)) begin
            push_req   = 1'b1;
            push_word  = merged;
            pack_next  = 32'd0;
            index_next = 3'd0;
          end else begin
            pack_next  = merged;
            index_next = index + 3'd1;
          end
        end
      end
      FLUSH: begin
        if (fifo_empty) begin
          state_next = DONE;
          load_count = 1'b1;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath: edge detect, pack register, address/count and overflow flag.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      fv_d       <= 1'b0;
      pack       <= 32'd0;
      index      <= 3'd0;
      mode       <= BPP8;
      ram_addr   <= '0;
      wcount     <= '0;
      word_count <= '0;
      overflow   <= 1'b0;
    end else begin
      fv_d  <= fv_in;
      pack  <= pack_next;
      index <= index_next;
      if (start_frame) begin
        mode     <= decode_mode(bpp_mode);
        ram_addr <= '0;
        wcount   <= '0;
        overflow <= 1'b0;
      end else begin
        if (write_fire) begin
          wcount <= wcount + 1'b1;
          if (ram_addr != ADDR_LAST) ram_addr <= ram_addr + 1'b1;
        end
        if (drop_push || discard) overflow <= 1'b1;
      end
      if (load_count) word_count <= wcount;
    end
  end

`ifdef FRAME_CHECKSUM_EN
  // Running 16-bit sum of both halves of every word that reaches the RAM.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      checksum <= 16'd0;
    end else if (start_frame) begin
      checksum <= 16'd0;
    end else if (write_fire) begin
      checksum <= checksum + ram_wdata[31:16] + ram_wdata[15:0];
    end
  end
`endif

endmodule

// File: tb/tb_frame_buffer_writer.sv
// Self-checking bench for frame_buffer_writer: directed frames from the
// design notes plus randomized frames against a packing reference model.
module tb_frame_buffer_writer;

  logic        clk;
  logic        reset_n;
  logic        capture_en;
  logic [1:0]  bpp_mode;
  logic [9:0]  pixel_data;
  logic        pixel_valid;
  logic        fv_in;
  logic        ram_ready;

  logic        ram_we;
  logic [13:0] ram_addr;
  logic [31:0] ram_wdata;
  logic        busy;
  logic        frame_done;
  logic [14:0] word_count;
  logic        overflow;

  logic        s_ram_we;
  logic [13:0] s_ram_addr;
  logic [31:0] s_ram_wdata;
  logic        s_busy;
  logic        s_frame_done;
  logic [14:0] s_word_count;
  logic        s_overflow;
`ifdef FRAME_CHECKSUM_EN
  logic [15:0] checksum;
  logic [15:0] s_checksum;
`endif

  int tests_run    = 0;
  int tests_failed = 0;

  logic [13:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  logic [13:0] s_addr_q[$];
  logic [31:0] s_data_q[$];
  int          done_cnt   = 0;
  int          s_done_cnt = 0;

  logic [9:0]  pix_q[$];
  logic [31:0] exp_q[$];
  int          base_wr, base_done, base_s_wr;
  int          ready_rand    = 0;
  int          ready_low_run = 0;
  int          stall_start   = 0;
  int          stall_len     = 0;

  frame_buffer_writer dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .capture_en  (capture_en),
    .bpp_mode    (bpp_mode),
    .pixel_data  (pixel_data),
    .pixel_valid (pixel_valid),
    .fv_in       (fv_in),
    .ram_ready   (ram_ready),
    .ram_we      (ram_we),
    .ram_addr    (ram_addr),
    .ram_wdata   (ram_wdata),
    .busy        (busy),
    .frame_done  (frame_done),
    .word_count  (word_count),
    .overflow    (overflow)
`ifdef FRAME_CHECKSUM_EN
    ,
    .checksum    (checksum)
`endif
  );

  frame_buffer_writer #(
    .MAX_WORDS (4)
  ) dut_small (
    .clk         (clk),
    .reset_n     (reset_n),
    .capture_en  (capture_en),
    .bpp_mode    (bpp_mode),
    .pixel_data  (pixel_data),
    .pixel_valid (pixel_valid),
    .fv_in       (fv_in),
    .ram_ready   (ram_ready),
    .ram_we      (s_ram_we),
    .ram_addr    (s_ram_addr),
    .ram_wdata   (s_ram_wdata),
    .busy        (s_busy),
    .frame_done  (s_frame_done),
    .word_count  (s_word_count),
    .overflow    (s_overflow)
`ifdef FRAME_CHECKSUM_EN
    ,
    .checksum    (s_checksum)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Write and frame_done monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (ram_we && ram_ready) begin
      wr_addr_q.push_back(ram_addr);
      wr_data_q.push_back(ram_wdata);
    end
    if (s_ram_we && ram_ready) begin
      s_addr_q.push_back(s_ram_addr);
      s_data_q.push_back(s_ram_wdata);
    end
    if (frame_done)   done_cnt++;
    if (s_frame_done) s_done_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (ready_rand != 0) begin
      if (ready_low_run >= 2) ram_ready = 1'b1;
      else                    ram_ready = 1'($urandom_range(0, 1));
      ready_low_run = ram_ready ? 0 : ready_low_run + 1;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    tests_run++;
    assert (observed === expected)
    else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Reference packing: pixel k of a word sits at bit k*(32/ppw), masked to
  // the mode width; a trailing partial word keeps its unused lanes zero.
  function automatic void build_expected(input int mode);
    int          ppw;
    int          lw;
    int          n;
    logic [31:0] word;
    logic [31:0] mask;
    ppw  = (mode == 1) ? 8 : (mode == 2) ? 2 : 4;
    lw   = 32 / ppw;
    mask = (mode == 1) ? 32'hF : (mode == 2) ? 32'h3FF : 32'hFF;
    exp_q.delete();
    word = 32'd0;
    n    = 0;
    foreach (pix_q[i]) begin
      word = word | ((32'(pix_q[i]) & mask) << (n * lw));
      n++;
      if (n == ppw) begin
        exp_q.push_back(word);
        word = 32'd0;
        n    = 0;
      end
    end
    if (n != 0) exp_q.push_back(word);
  endfunction

  // Drive one armed frame from pix_q and wait for its frame_done.
  task automatic applyStimulus(input int mode, input bit gaps);
    int t;
    base_wr   = wr_data_q.size();
    base_s_wr = s_data_q.size();
    base_done = done_cnt;
    capture_en = 1'b1;
    bpp_mode   = 2'(mode);
    fv_in      = 1'b1;
    tick();
    for (int i = 0; i < pix_q.size(); i++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          pixel_valid = 1'b0;
          pixel_data  = 10'($urandom);
          tick();
        end
      end
      if (stall_len > 0) ram_ready = !(i >= stall_start && i < stall_start + stall_len);
      pixel_valid = 1'b1;
      pixel_data  = pix_q[i];
      tick();
    end
    if (stall_len > 0) ram_ready = 1'b1;
    pixel_valid = 1'b1;
    pixel_data  = 10'h3C3;
    fv_in       = 1'b0;
    tick();
    pixel_valid = 1'b0;
    t = 0;
    while (t < 400 && done_cnt == base_done) begin
      tick();
      t++;
    end
    checkOutput("frame_done_seen", 64'(done_cnt > base_done), 64'd1);
    repeat (4) tick();
    checkOutput("frame_done_once", 64'(done_cnt - base_done), 64'd1);
  endtask

  // Compare the main instance's writes against exp_q exactly.
  task automatic checkFrameWrites(input string tag);
    int          n;
    logic [15:0] sum;
    n   = wr_data_q.size() - base_wr;
    sum = 16'd0;
    checkOutput({tag, "_nwrites"}, 64'(n), 64'(exp_q.size()));
    for (int i = 0; i < n && i < exp_q.size(); i++) begin
      checkOutput({tag, "_addr"}, 64'(wr_addr_q[base_wr + i]), 64'(i));
      checkOutput({tag, "_data"}, 64'(wr_data_q[base_wr + i]), 64'(exp_q[i]));
    end
    foreach (exp_q[i]) sum = sum + exp_q[i][31:16] + exp_q[i][15:0];
    checkOutput({tag, "_word_count"}, 64'(word_count), 64'(exp_q.size()));
    checkOutput({tag, "_overflow"}, 64'(overflow), 64'd0);
`ifdef FRAME_CHECKSUM_EN
    checkOutput({tag, "_checksum"}, 64'(checksum), 64'(sum));
`else
    if (sum == 16'hFFFF) tick();
`endif
  endtask

  initial begin
    int n;
    int j;
    bit ok;
    reset_n     = 1'b0;
    capture_en  = 1'b0;
    bpp_mode    = 2'd0;
    pixel_data  = 10'd0;
    pixel_valid = 1'b0;
    fv_in       = 1'b0;
    ram_ready   = 1'b1;
    repeat (3) tick();

    // Reset state.
    checkOutput("rst_ram_we", 64'(ram_we), 64'd0);
    checkOutput("rst_ram_addr", 64'(ram_addr), 64'd0);
    checkOutput("rst_ram_wdata", 64'(ram_wdata), 64'd0);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_frame_done", 64'(frame_done), 64'd0);
    checkOutput("rst_word_count", 64'(word_count), 64'd0);
    checkOutput("rst_overflow", 64'(overflow), 64'd0);
    checkOutput("rst_small_busy", 64'(s_busy), 64'd0);
`ifdef FRAME_CHECKSUM_EN
    checkOutput("rst_checksum", 64'(checksum), 64'd0);
    checkOutput("rst_small_checksum", 64'(s_checksum), 64'd0);
`endif
    reset_n = 1'b1;
    tick();

    // Unarmed frame is ignored.
    base_wr    = wr_data_q.size();
    base_done  = done_cnt;
    capture_en = 1'b0;
    fv_in      = 1'b1;
    tick();
    pixel_valid = 1'b1;
    pixel_data  = 10'h55;
    repeat (6) tick();
    checkOutput("unarmed_busy", 64'(busy), 64'd0);
    pixel_valid = 1'b0;
    fv_in       = 1'b0;
    repeat (4) tick();
    checkOutput("unarmed_writes", 64'(wr_data_q.size() - base_wr), 64'd0);
    checkOutput("unarmed_done", 64'(done_cnt - base_done), 64'd0);

    // 8bpp, 16 pixels 0x01..0x10.
    pix_q.delete();
    for (int i = 1; i <= 16; i++) pix_q.push_back(10'(i));
    applyStimulus(0, 0);
    build_expected(0);
    checkOutput("bpp8_word0", 64'(exp_q[0]), 64'h04030201);
    checkFrameWrites("bpp8");

    // 4bpp, 10 pixels 0x1..0xA with a flushed partial word.
    pix_q.delete();
    for (int i = 1; i <= 10; i++) pix_q.push_back(10'(i));
    applyStimulus(1, 0);
    build_expected(1);
    checkFrameWrites("bpp4");
    checkOutput("bpp4_addr1", 64'(wr_data_q[base_wr + 1]), 64'h000000A9);

    // 10bpp, 3 pixels.
    pix_q = '{10'h3FF, 10'h155, 10'h2AA};
    applyStimulus(2, 0);
    build_expected(2);
    checkFrameWrites("bpp10");
    checkOutput("bpp10_addr0", 64'(wr_data_q[base_wr]), 64'h015503FF);

    // Capacity limit on the MAX_WORDS=4 instance: 24 pixels, 6 words.
    pix_q.delete();
    for (int i = 1; i <= 24; i++) pix_q.push_back(10'(i));
    applyStimulus(0, 0);
    build_expected(0);
    checkFrameWrites("cap_main");
    n = s_data_q.size() - base_s_wr;
    checkOutput("cap_nwrites", 64'(n), 64'd4);
    for (int i = 0; i < n && i < 4; i++) begin
      checkOutput("cap_addr", 64'(s_addr_q[base_s_wr + i]), 64'(i));
      checkOutput("cap_data", 64'(s_data_q[base_s_wr + i]), 64'(exp_q[i]));
    end
    checkOutput("cap_overflow", 64'(s_overflow), 64'd1);
    checkOutput("cap_word_count", 64'(s_word_count), 64'd4);

    // RAM stall of 40 cycles during 64 back-to-back pixels.
    pix_q.delete();
    for (int i = 0; i < 64; i++) pix_q.push_back(10'($urandom_range(0, 255)));
    stall_start = 8;
    stall_len   = 40;
    applyStimulus(0, 0);
    stall_len   = 0;
    build_expected(0);
    n = wr_data_q.size() - base_wr;
    checkOutput("stall_overflow", 64'(overflow), 64'd1);
    checkOutput("stall_word_count", 64'(word_count), 64'(n));
    checkOutput("stall_dropped", 64'(n < exp_q.size()), 64'd1);
    for (int i = 0; i < n; i++)
      checkOutput("stall_addr", 64'(wr_addr_q[base_wr + i]), 64'(i));
    for (int i = 0; i < 4 && i < n; i++)
      checkOutput("stall_head", 64'(wr_data_q[base_wr + i]), 64'(exp_q[i]));
    ok = 1'b1;
    j  = 0;
    for (int i = 0; i < n; i++) begin
      while (j < exp_q.size() && exp_q[j] != wr_data_q[base_wr + i]) j++;
      if (j >= exp_q.size()) ok = 1'b0;
      else j++;
    end
    checkOutput("stall_in_order", 64'(ok), 64'd1);

    // Reset mid-frame after 5 pixels, then a 4-pixel 0xAA frame.
    base_done  = done_cnt;
    capture_en = 1'b1;
    bpp_mode   = 2'd0;
    fv_in      = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      pixel_valid = 1'b1;
      pixel_data  = 10'(8'h11 * (i + 1));
      tick();
    end
    checkOutput("midrst_busy_before", 64'(busy), 64'd1);
    reset_n     = 1'b0;
    pixel_valid = 1'b0;
    fv_in       = 1'b0;
    repeat (2) tick();
    checkOutput("midrst_no_done", 64'(done_cnt - base_done), 64'd0);
    checkOutput("midrst_busy", 64'(busy), 64'd0);
    checkOutput("midrst_ram_we", 64'(ram_we), 64'd0);
    reset_n = 1'b1;
    tick();
    pix_q = '{10'hAA, 10'hAA, 10'hAA, 10'hAA};
    applyStimulus(0, 0);
    build_expected(0);
    checkFrameWrites("after_rst");
    checkOutput("after_rst_word", 64'(wr_data_q[base_wr]), 64'hAAAAAAAA);
`ifdef FRAME_CHECKSUM_EN
    checkOutput("after_rst_checksum", 64'(checksum), 64'h5554);
`endif

    // Randomized frames: random mode, length, gaps and bounded RAM stalls.
    for (int f = 0; f < 6; f++) begin
      int mode;
      int npix;
      mode = int'($urandom_range(0, 3));
      npix = int'($urandom_range(1, 40));
      pix_q.delete();
      for (int i = 0; i < npix; i++) pix_q.push_back(10'($urandom));
      ready_rand    = 1;
      ready_low_run = 0;
      applyStimulus(mode, 1);
      ready_rand = 0;
      ram_ready  = 1'b1;
      build_expected(mode);
      checkFrameWrites("rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
